// File: rtl/window_invert_filter_pkg.sv
// Shared definitions for window_invert_filter.
// Holds the mode encodings, pixel/window widths, the divide-by-9 reciprocal
// constant and two small helpers (pixel extraction and exact floor(sum/9)).
package window_invert_filter_pkg;

  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned WINDOW_W   = 72;
  localparam int unsigned ROW_SUM_W  = 10;  // 3 * 255 = 765
  localparam int unsigned SUM_W      = 12;  // 9 * 255 = 2295
  localparam int unsigned DIV9_MUL   = 7282;
  localparam int unsigned DIV9_SHIFT = 16;

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_INV      = 2'd1,
    MODE_MEAN     = 2'd2,
    MODE_INV_MEAN = 2'd3
  } mode_e;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Pixel p[r][c] of a packed {row2,row1,row0} window.
  function automatic pixel_t pixel_at(logic [WINDOW_W-1:0] win, int unsigned r, int unsigned c);
    return win[r*24 + c*8 +: PIXEL_W];
  endfunction

  // floor(sum/9) via reciprocal multiply; exact over 0..2295 and the product fits 24 bits.
  function automatic pixel_t mean9(logic [SUM_W-1:0] sum);
    return pixel_t'((24'(sum) * 24'(DIV9_MUL)) >> DIV9_SHIFT);
  endfunction

endpackage

// File: rtl/window_invert_filter_if.sv
// Stream interface for window_invert_filter.
// Carries the input window stream (window, valid, mode; no backpressure)
// and the output pixel stream (pixel, valid, ready).
//   master: producer/consumer side (drives window stream and out_ready)
//   slave : filter side (drives out_pixel/out_valid)
interface window_invert_filter_if;
  import window_invert_filter_pkg::*;

  logic [WINDOW_W-1:0] in_window;
  logic                in_window_valid;
  mode_e               mode;
  pixel_t              out_pixel;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_window, in_window_valid, mode, out_ready,
    input  out_pixel, out_valid
  );

  modport slave (
    input  in_window, in_window_valid, mode, out_ready,
    output out_pixel, out_valid
  );

endinterface

// File: rtl/window_invert_filter_pixel_fifo.sv
// pixel_fifo: first-word-fall-through output FIFO.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   wr_en      write request; accepted if not full or if a read happens same cycle
//   wr_data    data to store
//   rd_en      consumer ready; pops the head when the FIFO is non-empty
//   rd_data    head entry (0 when empty)
//   valid      FIFO non-empty
//   full       FIFO holds Depth entries
//   level      occupancy 0..Depth
module window_invert_filter_pixel_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             empty, do_rd, do_wr;

  assign empty = (level_q == '0);
  assign full  = (level_q == (PtrW+1)'(Depth));
  // A read frees the slot this cycle, so a write into a full FIFO still lands.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign valid   = ~empty;
  assign level   = level_q;

endmodule

// File: rtl/window_invert_filter.sv
// window_invert_filter: 3x3 window point/mean filter with optional inversion.
// A 3-stage pipeline (register inputs, row sums, total sum) feeds a FWFT
// output FIFO; results enter the FIFO on the 4th edge after acceptance.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   bus (slave)    in_window/in_window_valid/mode in, out_pixel/out_valid/out_ready
//   row_done       pulse when the last pixel of a row is written to the FIFO
//   frame_done     pulse when the last pixel of a frame is written
//   err_overflow   sticky: a result was dropped on a full FIFO
//   fifo_level     FIFO occupancy
module window_invert_filter
  import window_invert_filter_pkg::*;
#(
  parameter int unsigned ROW_PIXELS = 512,
  parameter int unsigned FRAME_ROWS = 512,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  window_invert_filter_if.slave       bus,
  output logic                        row_done,
  output logic                        frame_done,
  output logic                        err_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PixW = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam int unsigned RowW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

  // Stage 1: registered inputs
  logic [WINDOW_W-1:0]  win_q;
  mode_e                mode1_q;
  logic                 v1_q;
  // Stage 2: row sums and centre
  logic [ROW_SUM_W-1:0] row_sum_d [3];
  logic [ROW_SUM_W-1:0] row_sum_q [3];
  pixel_t               centre2_q;
  mode_e                mode2_q;
  logic                 v2_q;
  // Stage 3: total and centre
  logic [SUM_W-1:0]     sum_d;
  logic [SUM_W-1:0]     sum3_q;
  pixel_t               centre3_q;
  mode_e                mode3_q;
  logic                 v3_q;

  pixel_t               mean, result;
  logic                 fifo_full, drop;
  logic [PixW-1:0]      pix_cnt_q;
  logic [RowW-1:0]      row_cnt_q;
  logic                 last_pix, last_row;
  logic                 row_done_q, frame_done_q, err_q;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      row_sum_d[r] = ROW_SUM_W'(pixel_at(win_q, r, 0)) + ROW_SUM_W'(pixel_at(win_q, r, 1))
                   + ROW_SUM_W'(pixel_at(win_q, r, 2));
    end
  end

  assign sum_d = SUM_W'(row_sum_q[0]) + SUM_W'(row_sum_q[1]) + SUM_W'(row_sum_q[2]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q     <= '0;
      mode1_q   <= MODE_PASS;
      v1_q      <= 1'b0;
      row_sum_q <= '{default: '0};
      centre2_q <= '0;
      mode2_q   <= MODE_PASS;
      v2_q      <= 1'b0;
      sum3_q    <= '0;
      centre3_q <= '0;
      mode3_q   <= MODE_PASS;
      v3_q      <= 1'b0;
    end else begin
      // Mode is captured alongside its window and travels down the pipe.
      win_q     <= bus.in_window;
      mode1_q   <= bus.mode;
      v1_q      <= bus.in_window_valid;
      row_sum_q <= row_sum_d;
      centre2_q <= pixel_at(win_q, 1, 1);
      mode2_q   <= mode1_q;
      v2_q      <= v1_q;
      sum3_q    <= sum_d;
      centre3_q <= centre2_q;
      mode3_q   <= mode2_q;
      v3_q      <= v2_q;
    end
  end

  // 255 - x equals ~x for 8-bit pixels.
  always_comb begin
    mean   = mean9(sum3_q);
    result = centre3_q;
    unique case (mode3_q)
      MODE_PASS:     result = centre3_q;
      MODE_INV:      result = ~centre3_q;
      MODE_MEAN:     result = mean;
      MODE_INV_MEAN: result = ~mean;
      default:       result = centre3_q;
    endcase
  end

  // Full FIFO implies out_valid, so ready alone decides whether a slot frees up.
  assign drop     = v3_q & fifo_full & ~bus.out_ready;
  assign last_pix = (pix_cnt_q == PixW'(ROW_PIXELS - 1));
  assign last_row = (row_cnt_q == RowW'(FRAME_ROWS - 1));

  // Counters track results leaving stage 3, including dropped ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      row_done_q   <= v3_q & last_pix;
      frame_done_q <= v3_q & last_pix & last_row;
      err_q        <= err_q | drop;
      if (v3_q) begin
        if (last_pix) begin
          pix_cnt_q <= '0;
          row_cnt_q <= last_row ? '0 : row_cnt_q + 1'b1;
        end else begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
      end
    end
  end

  window_invert_filter_pixel_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PIXEL_W)
  ) u_pixel_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (v3_q),
    .wr_data (result),
    .rd_en   (bus.out_ready),
    .rd_data (bus.out_pixel),
    .valid   (bus.out_valid),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign row_done     = row_done_q;
  assign frame_done   = frame_done_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_window_invert_filter.sv
// Scoreboard bench for window_invert_filter: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every accepted output.
module tb_window_invert_filter;
  import window_invert_filter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       row_done, frame_done, err_overflow;
  logic [3:0] fifo_level;

  window_invert_filter_if bus ();

  window_invert_filter #(
    .ROW_PIXELS (512),
    .FRAME_ROWS (2),
    .FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .row_done     (row_done),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  bit          rec_en = 1'b0;
  int          rd_idx[$];
  int          fd_idx[$];
  bit          stall_seen = 1'b0;
  logic [7:0]  stall_pix;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (stall_seen) check("stable_pixel", 32'(bus.out_pixel), 32'(stall_pix));
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", bus.out_pixel);
        end else begin
          check("out_pixel", 32'(bus.out_pixel), 32'(exp_q.pop_front()));
        end
        stall_seen = 1'b0;
      end else begin
        stall_seen = 1'b1;
        stall_pix  = bus.out_pixel;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // Row/frame pulse recorder: index of the result that caused the pulse.
  always @(negedge clk) begin
    if (rec_en) begin
      if (row_done)   rd_idx.push_back(int'(cyc - c0) - 4);
      if (frame_done) fd_idx.push_back(int'(cyc - c0) - 4);
    end
  end

  function automatic logic [71:0] uni(input logic [7:0] p, input logic [7:0] c);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = p;
    w[32 +: 8] = c;
    return w;
  endfunction

  function automatic logic [71:0] pat(input int k);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(k * 7 + i * 29);
    return w;
  endfunction

  function automatic logic [7:0] model(input logic [71:0] w, input mode_e m);
    int         s;
    logic [7:0] c;
    logic [7:0] mn;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i*8 +: 8]);
    c  = w[32 +: 8];
    mn = 8'(s / 9);
    case (m)
      MODE_PASS: return c;
      MODE_INV:  return 8'(255 - int'(c));
      MODE_MEAN: return mn;
      default:   return 8'(255 - int'(mn));
    endcase
  endfunction

  task automatic send(input logic [71:0] w, input mode_e m, input logic [7:0] exp,
                      input bit push);
    bus.in_window       = w;
    bus.mode            = m;
    bus.in_window_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_window_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.in_window_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] w;
    mode_e       m;
    int          lat;

    rst                 = 1'b0;
    bus.in_window       = '0;
    bus.in_window_valid = 1'b0;
    bus.mode            = MODE_PASS;
    bus.out_ready       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    check("rst_row_done", 32'(row_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    idle(2);

    // Latency: 8*10 + 200 = 280, floor(280/9) = 31
    send(uni(8'd10, 8'd200), MODE_MEAN, 8'd31, 1'b1);
    bus.in_window_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("latency_pixel", 32'(bus.out_pixel), 32'd31);

    // Directed vectors, back-to-back with mode changing every window
    bus.out_ready = 1'b1;
    send(uni(8'd10, 8'd200), MODE_INV_MEAN, 8'd224, 1'b1);
    send(uni(8'hFF, 8'hFF), MODE_MEAN, 8'd255, 1'b1);
    send(uni(8'h00, 8'h00), MODE_INV_MEAN, 8'd255, 1'b1);
    send(uni(8'h11, 8'h37), MODE_INV, 8'hC8, 1'b1);
    send(uni(8'h11, 8'h5A), MODE_PASS, 8'h5A, 1'b1);
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(i + 1);  // sum 45
    send(w, MODE_MEAN, 8'd5, 1'b1);
    send(w, MODE_INV_MEAN, 8'd250, 1'b1);
    w = uni(8'd0, 8'd0);
    w[7:0] = 8'd8;                                         // sum 8 -> 0
    send(w, MODE_MEAN, 8'd0, 1'b1);
    w[7:0] = 8'd9;                                         // sum 9 -> 1
    send(w, MODE_MEAN, 8'd1, 1'b1);
    send(uni(8'hFF, 8'hFE), MODE_MEAN, 8'd254, 1'b1);      // sum 2294 -> 254
    drain("directed");

    // Overflow: 12 windows into a stalled 8-deep FIFO, last 4 dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(uni(8'd0, 8'(i + 1)), MODE_PASS, 8'(i + 1), i < 8);
    idle(6);
    check("ovf_level", 32'(fifo_level), 32'd8);
    check("ovf_err", 32'(err_overflow), 32'd1);
    bus.out_ready = 1'b1;
    drain("ovf");
    check("ovf_level_empty", 32'(fifo_level), 32'd0);
    check("ovf_err_sticky", 32'(err_overflow), 32'd1);

    // Reset with 5 results in the FIFO and 3 in the pipeline
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(uni(8'd0, 8'(8'h40 + i)), MODE_PASS, 8'd0, 1'b0);
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    rst = 1'b0;
    idle(1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_pixel", 32'(bus.out_pixel), 32'd0);
    check("mid_rst_err", 32'(err_overflow), 32'd0);
    rst = 1'b1;
    idle(8);
    check("post_rst_level", 32'(fifo_level), 32'd0);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Full frame: 2 rows of 512; FIFO fills to 8 then runs full with ready=1
    c0     = cyc;
    rec_en = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      if (k == 11) bus.out_ready = 1'b1;
      if (k == 40 || k == 300 || k == 900) check("full_level", 32'(fifo_level), 32'd8);
      w = pat(k);
      m = mode_e'(2'(k));
      send(w, m, model(w, m), 1'b1);
    end
    drain("frame");
    rec_en = 1'b0;
    check("frame_err", 32'(err_overflow), 32'd0);
    check("row_done_count", 32'(rd_idx.size()), 32'd2);
    check("row_done_0", 32'(rd_idx.size() > 0 ? rd_idx[0] : -1), 32'd511);
    check("row_done_1", 32'(rd_idx.size() > 1 ? rd_idx[1] : -1), 32'd1023);
    check("frame_done_count", 32'(fd_idx.size()), 32'd1);
    check("frame_done_0", 32'(fd_idx.size() > 0 ? fd_idx[0] : -1), 32'd1023);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
